if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage that produces the `if_to_id_bus` consumed by the decode stage and acts on the `br_bus` redirect that decode returns. It owns the PC register and drives the synchronous instruction SRAM port. It also holds the fetched instruction stable across pipeline stalls, so decode never has to latch SRAM read data itself. It sits between the stall controller, the instruction SRAM and the decode stage.

## Interface
Parameters:
- RESET_PC, 32'hBFBF_FFFC: PC value held in reset. The first fetched address is RESET_PC+4, which is 32'hBFC0_0000.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  `StallBus` (6)  stall vector, Stop=1. stall[0] freezes the PC; stall[1] freezes the IF/ID boundary.
- br_bus  in  `BR_WD` (33)  {br_e, br_addr[31:0]} from decode; combinational, same cycle.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_wen  out  4  always 4'b0000.
- inst_sram_addr  out  32  read address (next PC).
- inst_sram_wdata  out  32  always 0.
- inst_sram_rdata  in  32  read data, valid one cycle after the address is presented.
- if_to_id_bus  out  `IF_TO_ID_WD` (33)  {ce, pc[31:0]}.
- if_inst  out  32  instruction for the pc in if_to_id_bus.
- if_adel  out  1  misaligned-fetch flag. Only active with IF_ADEL_EN.

## Operation
- Registers: pc_r (32), ce_r (1), br_pend (1), br_tgt (32), hold_r (32), state.
- next_pc selection, by priority:
  - br_e=1: br_addr.
  - else br_pend=1: br_tgt.
  - else: pc_r+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- PC update: when stall[0]=0, pc_r<=next_pc, ce_r<=1, br_pend<=0. When stall[0]=1, pc_r and ce_r hold.
- Redirect capture: if br_e=1 while stall[0]=1, set br_pend<=1 and br_tgt<=br_addr. A later br_e overwrites br_tgt. The redirect must not be lost across a stall.
- SRAM port: inst_sram_en = ~rst & ~stall[0]; inst_sram_addr = next_pc.
- Delay slot: there is no flush. The instruction after a branch is always fetched and passed on.
- Hold FSM:
  - RESET: entered during rst. if_inst=0. Goes to RUN on the first cycle with rst=0 and stall[0]=0.
  - RUN: if_inst = inst_sram_rdata. If stall[1]=1, capture hold_r<=inst_sram_rdata and go to HOLD.
  - HOLD: if_inst = hold_r and the SRAM is not re-read. When stall[1]=0, return to RUN; if_inst is still hold_r during that release cycle.
- ce=0 (reset or bubble) forces if_inst=0, which is a nop.
- Reset values: pc_r=RESET_PC, ce_r=0, br_pend=0, br_tgt=0, hold_r=0, state=RESET, if_inst=0, if_adel=0, inst_sram_en=0.
- A reset asserted in the middle of HOLD or of a pending redirect discards both; the next cycle behaves like power-up.

## Timing
- Cycle n: next_pc is presented to the SRAM. Cycle n+1: pc_r=next_pc and inst_sram_rdata belongs to pc_r.
- Branch latency: br_e in cycle n (not stalled) gives pc_r=br_addr in cycle n+1.
- br_e arriving while stalled takes effect in the first cycle with stall[0]=0, through br_pend.
- Simultaneous live br_e and br_pend: the live br_addr wins.
- HOLD entry costs no bubble, and HOLD exit inserts no extra cycle.

## Configuration
- IF_ADEL_EN defined:
  - if_adel = ce_r & (pc_r[1:0] != 0).
  - While if_adel=1: if_inst=0, and inst_sram_en=0 whenever next_pc[1:0] != 0.
- IF_ADEL_EN undefined: if_adel is tied 0 and addresses are issued unchecked.

## Structure
- Shared defines header (lib/defines.vh) holds StallBus, BR_WD, IF_TO_ID_WD, Stop/NoStop and the reset PC constant.
- No sub-module. The hold FSM and the redirect capture live inline.

## Test plan
- Reset release with no stalls: addresses 32'hBFC0_0000, 32'hBFC0_0004, ...; if_to_id_bus = {1, 32'hBFC0_0000} one cycle after the first address.
- br_e=1 with br_addr=32'hBFC0_0100 while unstalled: pc 32'hBFC0_0100 on the next cycle, and the delay-slot instruction is still delivered.
- stall[0]=stall[1]=1 for 3 cycles while rdata changes to 32'hDEADBEEF: if_inst keeps the captured 32'h2402_0001, inst_sram_en=0, and the PC holds.
- br_e pulse to 32'hBFC0_0200 during a stall, then release: first post-stall pc = 32'hBFC0_0200.
- rst asserted in HOLD: next cycle pc=RESET_PC, ce=0, if_inst=0.
- IF_ADEL_EN build, br_addr=32'hBFC0_0102: if_adel=1 and if_inst=0; non-ADEL build: if_adel=0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, reset PC and hold-FSM encoding for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int STALL_W     = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFBF_FFFC;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } hold_state_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: stall vector, branch redirect, instruction SRAM port and IF/ID outputs.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            inst_sram_rdata;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [31:0]            if_inst;
    logic                   if_adel;

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output if_to_id_bus, if_inst, if_adel
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  if_to_id_bus, if_inst, if_adel
    );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: PC register, redirect capture across stalls, and an instruction hold FSM.
// Optional misaligned-fetch detection is enabled with `define IF_ADEL_EN.
//
// state    | meaning
// ST_RESET | no valid fetch yet; if_inst = 0
// ST_RUN   | if_inst follows inst_sram_rdata
// ST_HOLD  | IF/ID stalled; if_inst replays the captured word, SRAM not re-read
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] pc_r;
    logic [31:0] next_pc;
    logic [31:0] br_tgt;
    logic [31:0] hold_r;
    logic        ce_r;
    logic        br_pend;
    logic        adel;
    logic        hold_cap;
    logic [31:0] inst_sel;
    logic        unused_stall;

    hold_state_t state_q, state_nx;

    assign br_e         = bus.br_bus[32];
    assign br_addr      = bus.br_bus[31:0];
    assign unused_stall = ^bus.stall[STALL_W-1:2];

    // Live redirect beats a pending one so the newest decode decision wins.
    always_comb begin
        next_pc = pc_r + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (br_pend) begin
            next_pc = br_tgt;
        end
    end

`ifdef IF_ADEL_EN
    assign adel             = ce_r & misaligned(pc_r);
    assign bus.inst_sram_en = ~rst & ~bus.stall[0] & ~(adel & misaligned(next_pc));
`else
    assign adel             = 1'b0;
    assign bus.inst_sram_en = ~rst & ~bus.stall[0];
`endif

    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_wdata = 32'd0;
    assign bus.inst_sram_addr  = next_pc;
    assign bus.if_to_id_bus    = {ce_r, pc_r};
    assign bus.if_adel         = adel;
    assign bus.if_inst         = (ce_r & ~adel) ? inst_sel : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            ce_r    <= 1'b0;
            br_pend <= 1'b0;
            br_tgt  <= 32'd0;
        end else if (bus.stall[0] == NO_STOP) begin
            pc_r    <= next_pc;
            ce_r    <= 1'b1;
            br_pend <= 1'b0;
        end else if (br_e) begin
            br_pend <= 1'b1;
            br_tgt  <= br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            hold_r  <= 32'd0;
        end else begin
            state_q <= state_nx;
            if (hold_cap) begin
                hold_r <= bus.inst_sram_rdata;
            end
        end
    end

    // HOLD keeps driving hold_r through the release cycle; RUN resumes when fresh data lands.
    always_comb begin
        state_nx = state_q;
        hold_cap = 1'b0;
        inst_sel = 32'd0;
        case (state_q)
            ST_RESET: begin
                if (bus.stall[0] == NO_STOP) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                inst_sel = bus.inst_sram_rdata;
                if (bus.stall[1] == STOP) begin
                    hold_cap = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                inst_sel = hold_r;
                if (bus.stall[1] == NO_STOP) begin
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: stimulus pushes per-cycle expectations, a negedge monitor compares.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'hBFBF_FFFC;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
        logic [31:0] addr;
        logic        en;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_if bus();

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_pc, m_tgt;
    logic        m_ce, m_pend;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2402_0001;
    endfunction

    function automatic logic mis(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    // Instruction SRAM: disabled cycles return junk so a missing hold shows up.
    always @(posedge clk)
        bus.inst_sram_rdata <= bus.inst_sram_en ? mem_word(bus.inst_sram_addr) : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("ce",         64'(bus.if_to_id_bus[32]),   64'(e.ce));
            chk("pc",         64'(bus.if_to_id_bus[31:0]), 64'(e.pc));
            chk("if_inst",    64'(bus.if_inst),            64'(e.inst));
            chk("if_adel",    64'(bus.if_adel),            64'(e.adel));
            chk("sram_addr",  64'(bus.inst_sram_addr),     64'(e.addr));
            chk("sram_en",    64'(bus.inst_sram_en),       64'(e.en));
            chk("sram_wen",   64'(bus.inst_sram_wen),      64'd0);
            chk("sram_wdata", 64'(bus.inst_sram_wdata),    64'd0);
        end
    end

    // Entered just after a rising edge: apply inputs, predict this cycle, then advance the model.
    task automatic step(input bit r, input bit s, input bit be, input logic [31:0] ba);
        exp_t        e;
        logic [31:0] nxt;
        rst         = r;
        bus.stall   = {4'b0000, s, s};
        bus.br_bus  = {be, ba};
        nxt = be ? ba : (m_pend ? m_tgt : m_pc + 32'd4);
        e.ce   = m_ce;
        e.pc   = m_pc;
`ifdef IF_ADEL_EN
        e.adel = m_ce && mis(m_pc);
`else
        e.adel = 1'b0;
`endif
        e.inst = (m_ce && !e.adel) ? mem_word(m_pc) : 32'd0;
        e.addr = nxt;
        e.en   = !r && !s && !(e.adel && mis(nxt));
        sbq.push_back(e);
        @(posedge clk);
        if (r) begin
            m_pc = RPC; m_ce = 1'b0; m_pend = 1'b0; m_tgt = 32'd0;
        end else if (!s) begin
            m_pc = nxt; m_ce = 1'b1; m_pend = 1'b0;
        end else if (be) begin
            m_pend = 1'b1; m_tgt = ba;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_left;
        rst        = 1'b1;
        bus.stall  = '0;
        bus.br_bus = '0;
        m_pc = RPC; m_ce = 1'b0; m_pend = 1'b0; m_tgt = 32'd0;
        @(posedge clk);
        #1;

        repeat (3) step(1, 0, 0, 32'd0);
        repeat (5) step(0, 0, 0, 32'd0);

        step(0, 0, 1, 32'hBFC0_0100);
        repeat (3) step(0, 0, 0, 32'd0);

        repeat (3) step(0, 1, 0, 32'd0);
        repeat (2) step(0, 0, 0, 32'd0);

        step(0, 1, 0, 32'd0);
        step(0, 1, 1, 32'hBFC0_0200);
        step(0, 1, 0, 32'd0);
        repeat (3) step(0, 0, 0, 32'd0);

        step(0, 1, 1, 32'hBFC0_0300);
        step(0, 0, 1, 32'hBFC0_0400);
        repeat (2) step(0, 0, 0, 32'd0);

        step(0, 1, 0, 32'd0);
        step(0, 1, 1, 32'hBFC0_0500);
        step(1, 1, 0, 32'd0);
        step(0, 1, 0, 32'd0);
        repeat (3) step(0, 0, 0, 32'd0);

        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (3) step(0, 0, 0, 32'd0);

        step(0, 0, 1, 32'hBFC0_0102);
        repeat (2) step(0, 0, 0, 32'd0);
        step(0, 0, 1, 32'hBFC0_0000);
        repeat (2) step(0, 0, 0, 32'd0);

        stall_left = 0;
        for (int i = 0; i < 600; i++) begin
            bit          r, s, be;
            logic [31:0] ba;
            r = ($urandom % 150) == 0;
            if (stall_left > 0) begin
                s = 1'b1;
                stall_left--;
            end else if (($urandom % 5) == 0) begin
                s = 1'b1;
                stall_left = int'($urandom_range(0, 3));
            end else begin
                s = 1'b0;
            end
            be = ($urandom % 6) == 0;
            ba = 32'hBFC0_0000 + (32'($urandom_range(0, 511)) << 2);
            if (($urandom % 10) == 0) ba[1:0] = 2'($urandom_range(1, 3));
            step(r, s, be, ba);
        end

        step(0, 0, 0, 32'd0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
